// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: PC register, ROM address/issue control, HALT detection and issue counter.
// Issue is combinational from InstIn in RUN; stall holds PC and count with no issue; start restarts at START_ADDR.
module inst_fetch_seq #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [9:0] HALT_WORD  = 10'b0000000000,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [7:0]       branch_target,
  output logic [7:0]       InstAddress,
  input  logic [9:0]       InstIn,
  output logic [9:0]       instr_out,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetchState_t      state;
  fetchState_t      stateNext;
  logic [7:0]       pc;
  logic [7:0]       pcNext;
  logic [CNT_W-1:0] issueCnt;
  logic [CNT_W-1:0] issueCntNext;

  logic running;
  logic isHaltWord;
  logic issueFire;
  logic cntSaturated;

  assign running      = (state == RUN);
  assign isHaltWord   = (InstIn == HALT_WORD);
  assign issueFire    = running && !stall && !isHaltWord;
  assign cntSaturated = (issueCnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= START_ADDR;
      issueCnt <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      issueCnt <= issueCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    issueCntNext = issueCnt;
    case (state)
      IDLE: begin
        pcNext = START_ADDR;
        if (start) begin
          stateNext    = RUN;
          issueCntNext = '0;
        end
      end
      RUN: begin
        // start beats stall, branch and halt detection
        if (start) begin
          pcNext       = START_ADDR;
          issueCntNext = '0;
        end else if (!stall) begin
          if (isHaltWord) begin
            stateNext = HALTED;
          end else begin
            pcNext = branch_taken ? branch_target : pc + 8'd1;
            if (!cntSaturated) begin
              issueCntNext = issueCnt + CNT_ONE;
            end
          end
        end
      end
      HALTED: begin
        if (start) begin
          stateNext    = RUN;
          pcNext       = START_ADDR;
          issueCntNext = '0;
        end
      end
      default: begin
        stateNext    = IDLE;
        pcNext       = START_ADDR;
        issueCntNext = '0;
      end
    endcase
  end

  assign InstAddress = pc;
  assign instr_out   = running ? InstIn : 10'b0;
  assign instr_valid = issueFire;
  assign halted      = (state == HALTED);
  assign issue_count = issueCnt;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: a default-width and a 4-bit-counter instance share stimulus and a ROM,
// checked by directed scenarios and a randomized run against a behavioural model.
module tb_inst_fetch_seq;

  localparam logic [9:0] HALT = 10'd0;

  logic        clk = 1'b0;
  logic        reset, start, stall, branchTaken;
  logic [7:0]  branchTarget;
  logic [7:0]  addrA, addrB;
  logic [9:0]  instA, instB, outA, outB;
  logic        vldA, vldB, hltA, hltB;
  logic [15:0] cntA;
  logic [3:0]  cntB;
  logic [9:0]  rom [0:255];

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit mRun, mHalt;
  int mPc, mCnt, mCntS;

  always #5 clk = ~clk;

  assign instA = rom[addrA];
  assign instB = rom[addrB];

  inst_fetch_seq dutA (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branchTaken), .branch_target(branchTarget),
    .InstAddress(addrA), .InstIn(instA), .instr_out(outA),
    .instr_valid(vldA), .halted(hltA), .issue_count(cntA)
  );

  inst_fetch_seq #(.CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branchTaken), .branch_target(branchTarget),
    .InstAddress(addrB), .InstIn(instB), .instr_out(outB),
    .instr_valid(vldB), .halted(hltB), .issue_count(cntB)
  );

  task automatic drive(input bit rs, input bit st, input bit sl, input bit br, input logic [7:0] tgt);
    reset = rs; start = st; stall = sl; branchTaken = br; branchTarget = tgt;
    #1;
  endtask

  task automatic advance();
    if (reset) begin
      mRun = 0; mHalt = 0; mPc = 0; mCnt = 0; mCntS = 0;
    end else if (start) begin
      mRun = 1; mHalt = 0; mPc = 0; mCnt = 0; mCntS = 0;
    end else if (mRun && !stall) begin
      if (rom[mPc] == HALT) begin
        mRun = 0; mHalt = 1;
      end else begin
        mCnt  = (mCnt < 65535) ? mCnt + 1 : 65535;
        mCntS = (mCntS < 15) ? mCntS + 1 : 15;
        mPc   = branchTaken ? int'(branchTarget) : (mPc + 1) % 256;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fillRom(input int haltAt);
    for (int i = 0; i < 256; i++) rom[i] = 10'($urandom_range(1, 1023));
    if (haltAt >= 0) rom[haltAt] = HALT;
  endtask

  task automatic test_reset();
    fillRom(-1);
    drive(1, 1, 1, 1, 8'($urandom));
    advance();
    advance();
    total += 5;
    if (addrA !== 8'h00) begin bad++; $display("FAIL rst_addr: got %0h want 0", addrA); end
    if (outA !== 10'h0 || vldA !== 1'b0) begin bad++; $display("FAIL rst_issue: got out=%0h vld=%0b want 0/0", outA, vldA); end
    if (hltA !== 1'b0) begin bad++; $display("FAIL rst_halted: got %0b want 0", hltA); end
    if (cntA !== 16'd0) begin bad++; $display("FAIL rst_cntA: got %0d want 0", cntA); end
    if (cntB !== 4'd0) begin bad++; $display("FAIL rst_cntB: got %0d want 0", cntB); end
    drive(0, 0, 0, 1, 8'h33);
    advance();
    total += 2;
    if (addrA !== 8'h00) begin bad++; $display("FAIL idle_addr: got %0h want 0", addrA); end
    if (vldA !== 1'b0 || hltA !== 1'b0) begin bad++; $display("FAIL idle_flags: got vld=%0b hlt=%0b want 0/0", vldA, hltA); end
  endtask

  task automatic test_linear();
    fillRom(4);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      total += 3;
      if (addrA !== 8'(i)) begin bad++; $display("FAIL lin_addr%0d: got %0h want %0h", i, addrA, i); end
      if (vldA !== (i < 4)) begin bad++; $display("FAIL lin_vld%0d: got %0b want %0b", i, vldA, i < 4); end
      if (outA !== rom[i]) begin bad++; $display("FAIL lin_out%0d: got %0h want %0h", i, outA, rom[i]); end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (hltA !== 1'b1 || hltB !== 1'b1) begin bad++; $display("FAIL lin_halted%0d: got %0b/%0b want 1", i, hltA, hltB); end
      if (cntA !== 16'd4 || cntB !== 4'd4) begin bad++; $display("FAIL lin_cnt%0d: got %0d/%0d want 4", i, cntA, cntB); end
      if (addrA !== 8'd4 || vldA !== 1'b0) begin bad++; $display("FAIL lin_frozen%0d: got addr=%0h vld=%0b want 4/0", i, addrA, vldA); end
      drive(0, 0, i[0], 1, 8'h40);
      advance();
    end
  endtask

  task automatic test_branch();
    fillRom(-1);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    advance();
    advance();
    drive(0, 0, 0, 1, 8'h09);
    total += 2;
    if (addrA !== 8'd2 || vldA !== 1'b1) begin bad++; $display("FAIL br_pre: got addr=%0h vld=%0b want 2/1", addrA, vldA); end
    if (outA !== rom[2]) begin bad++; $display("FAIL br_out: got %0h want %0h", outA, rom[2]); end
    advance();
    drive(0, 0, 0, 0, 8'h00);
    total += 2;
    if (addrA !== 8'h09) begin bad++; $display("FAIL br_addr: got %0h want 09", addrA); end
    if (cntA !== 16'd3) begin bad++; $display("FAIL br_cnt: got %0d want 3", cntA); end
  endtask

  task automatic test_stall_branch();
    fillRom(-1);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    repeat (5) advance();
    drive(0, 0, 1, 1, 8'($urandom_range(16, 255)));
    for (int i = 0; i < 3; i++) begin
      total += 2;
      if (addrA !== 8'd5 || vldA !== 1'b0) begin bad++; $display("FAIL stl_hold%0d: got addr=%0h vld=%0b want 5/0", i, addrA, vldA); end
      if (cntA !== 16'd5) begin bad++; $display("FAIL stl_cnt%0d: got %0d want 5", i, cntA); end
      advance();
    end
    drive(0, 0, 0, 0, 8'h00);
    total += 1;
    if (addrA !== 8'd5 || vldA !== 1'b1) begin bad++; $display("FAIL stl_rel: got addr=%0h vld=%0b want 5/1", addrA, vldA); end
    advance();
    total += 1;
    if (addrA !== 8'd6 || cntA !== 16'd6) begin bad++; $display("FAIL stl_adv: got addr=%0h cnt=%0d want 6/6", addrA, cntA); end
  endtask

  task automatic test_wrap();
    fillRom(-1);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 1, 8'hFF);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    total += 1;
    if (addrA !== 8'hFF || vldA !== 1'b1) begin bad++; $display("FAIL wrap_ff: got addr=%0h vld=%0b want ff/1", addrA, vldA); end
    advance();
    total += 1;
    if (addrA !== 8'h00 || vldA !== 1'b1) begin bad++; $display("FAIL wrap_00: got addr=%0h vld=%0b want 0/1", addrA, vldA); end
    advance();
    total += 2;
    if (cntA !== 16'd3) begin bad++; $display("FAIL wrap_cnt: got %0d want 3", cntA); end
    if (hltA !== 1'b0 || addrA !== 8'h01) begin bad++; $display("FAIL wrap_run: got hlt=%0b addr=%0h want 0/01", hltA, addrA); end
  endtask

  task automatic test_reset_midrun();
    fillRom(-1);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    repeat (7) advance();
    total += 1;
    if (addrA !== 8'd7 || cntA !== 16'd7) begin bad++; $display("FAIL mid_pre: got addr=%0h cnt=%0d want 7/7", addrA, cntA); end
    drive(1, 1, 0, 1, 8'h20);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    total += 2;
    if (addrA !== 8'h00 || cntA !== 16'd0 || cntB !== 4'd0) begin bad++; $display("FAIL mid_rst: got addr=%0h cnt=%0d/%0d want 0/0/0", addrA, cntA, cntB); end
    if (vldA !== 1'b0 || outA !== 10'h0 || hltA !== 1'b0) begin bad++; $display("FAIL mid_idle: got vld=%0b out=%0h hlt=%0b want 0/0/0", vldA, outA, hltA); end
    advance();
    drive(0, 1, 1, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    total += 1;
    if (addrA !== 8'h00 || vldA !== 1'b1) begin bad++; $display("FAIL mid_restart: got addr=%0h vld=%0b want 0/1", addrA, vldA); end
    advance();
    total += 1;
    if (addrA !== 8'h01 || cntA !== 16'd1) begin bad++; $display("FAIL mid_adv: got addr=%0h cnt=%0d want 1/1", addrA, cntA); end
  endtask

  task automatic test_saturation();
    fillRom(20);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    repeat (21) advance();
    total += 3;
    if (cntB !== 4'hF) begin bad++; $display("FAIL sat_cntB: got %0h want f", cntB); end
    if (cntA !== 16'd20) begin bad++; $display("FAIL sat_cntA: got %0d want 20", cntA); end
    if (hltB !== 1'b1 || addrB !== 8'd20) begin bad++; $display("FAIL sat_halt: got hlt=%0b addr=%0h want 1/14", hltB, addrB); end
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 1, 0, 8'h00);
    total += 2;
    if (cntB !== 4'd0 || cntA !== 16'd0) begin bad++; $display("FAIL sat_clr: got %0d/%0d want 0/0", cntA, cntB); end
    if (hltB !== 1'b0 || addrB !== 8'h00) begin bad++; $display("FAIL sat_restart: got hlt=%0b addr=%0h want 0/0", hltB, addrB); end
  endtask

  task automatic test_start_in_run();
    fillRom(-1);
    drive(0, 1, 0, 0, 8'h00);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    repeat (4) advance();
    rom[4] = HALT;
    drive(0, 1, 1, 1, 8'h55);
    advance();
    drive(0, 0, 0, 0, 8'h00);
    total += 2;
    if (addrA !== 8'h00 || cntA !== 16'd0) begin bad++; $display("FAIL sir_restart: got addr=%0h cnt=%0d want 0/0", addrA, cntA); end
    if (hltA !== 1'b0 || vldA !== 1'b1) begin bad++; $display("FAIL sir_run: got hlt=%0b vld=%0b want 0/1", hltA, vldA); end
  endtask

  task automatic test_random();
    logic [9:0] expOut;
    bit expVld;
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 9) == 0) ? HALT : 10'($urandom_range(1, 1023));
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, 8'($urandom));
      expVld = mRun && !stall && (rom[mPc] != HALT);
      expOut = mRun ? rom[mPc] : 10'h0;
      total += 5;
      if (addrA !== 8'(mPc) || addrB !== 8'(mPc)) begin bad++; $display("FAIL rnd_addr c=%0d: got %0h/%0h want %0h", c, addrA, addrB, mPc); end
      if (vldA !== expVld || vldB !== expVld) begin bad++; $display("FAIL rnd_vld c=%0d: got %0b/%0b want %0b", c, vldA, vldB, expVld); end
      if (outA !== expOut || outB !== expOut) begin bad++; $display("FAIL rnd_out c=%0d: got %0h/%0h want %0h", c, outA, outB, expOut); end
      if (hltA !== mHalt || hltB !== mHalt) begin bad++; $display("FAIL rnd_halt c=%0d: got %0b/%0b want %0b", c, hltA, hltB, mHalt); end
      if (cntA !== 16'(mCnt) || cntB !== 4'(mCntS)) begin bad++; $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, cntA, cntB, mCnt, mCntS); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_reset_midrun();
    test_saturation();
    test_start_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_seq.md
INST_FETCH_SEQ -- requirements
Module: inst_fetch_seq

Interface
REQ-001 Parameter START_ADDR, default 8'd0, meaning: PC value loaded on start.
REQ-002 Parameter HALT_WORD, default 10'b0000000000, meaning: instruction encoding that stops fetch.
REQ-003 Parameter CNT_W, default 16, meaning: width of issued-instruction counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock for all state.
REQ-006 Port: reset  input  1  synchronous active-high reset.
REQ-007 Port: start  input  1  single-cycle request to begin or restart execution at START_ADDR.
REQ-008 Port: stall  input  1  hold current PC and instruction; no issue this cycle.
REQ-009 Port: branch_taken  input  1  redirect fetch to branch_target next cycle.
REQ-010 Port: branch_target  input  8  absolute target address.
REQ-011 Port: InstAddress  output  8  address to instruction ROM; equals PC register.
REQ-012 Port: InstIn  input  10  combinational ROM data for InstAddress.
REQ-013 Port: instr_out  output  10  instruction issued to decode.
REQ-014 Port: instr_valid  output  1  instr_out is a valid issue this cycle.
REQ-015 Port: halted  output  1  fetch stopped on HALT_WORD.
REQ-016 Port: issue_count  output  CNT_W  instructions issued since last start.

Function
REQ-017 FSM states: IDLE, RUN, HALTED; 2-bit encoded state register.
REQ-018 IDLE: PC held at START_ADDR; start=1 -> RUN next cycle, PC=START_ADDR, issue_count=0.
REQ-019 RUN: instr_out = InstIn; instr_valid = 1 iff stall=0 and InstIn != HALT_WORD.
REQ-020 Outside RUN: instr_out = 10'b0, instr_valid = 0.
REQ-021 RUN, stall=1: PC, state, issue_count held; branch_taken ignored (stall has priority).
REQ-022 RUN, stall=0, InstIn == HALT_WORD: -> HALTED next cycle; PC held; branch_taken ignored; no issue, no count.
REQ-023 RUN, stall=0, InstIn != HALT_WORD, branch_taken=1: PC <= branch_target next cycle.
REQ-024 RUN, stall=0, InstIn != HALT_WORD, branch_taken=0: PC <= PC+1 modulo 256 (8'hFF wraps to 8'h00, no flag).
REQ-025 issue_count increments by 1 on each cycle with instr_valid=1; saturates at all-ones.
REQ-026 halted = 1 iff state == HALTED; registered, no combinational path from InstIn.
REQ-027 HALTED: PC and issue_count frozen; start=1 -> RUN next cycle, PC=START_ADDR, issue_count=0.
REQ-028 start=1 while in RUN: restart -- PC=START_ADDR, issue_count=0 next cycle, stays RUN; start overrides stall, branch and halt detection.
REQ-029 Latency: start sampled at edge N -> first fetch address on InstAddress after edge N, instr_valid same cycle (ROM combinational).
REQ-030 Branch latency: branch_taken at edge N -> InstAddress=branch_target after edge N; no delay slot.

Reset
REQ-031 reset=1 at a clock edge SHALL force state=IDLE, PC=START_ADDR, issue_count=0 regardless of other inputs, including mid-RUN and in HALTED.
REQ-032 During and after reset until start: InstAddress=START_ADDR, instr_out=0, instr_valid=0, halted=0.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 Linear run: ROM 0..3 nonzero, 4 = 0; pulse start -> addresses 0,1,2,3,4 on consecutive cycles, 4 valids, halted=1 from next cycle, issue_count=4.
REQ-035 Branch: ROM[2] issued with branch_taken=1, target 8'h09 -> next InstAddress=9, no issue of address 3; count increments once for address 2.
REQ-036 Stall/branch collision: stall=1 and branch_taken=1 for 3 cycles at PC=5 -> PC stays 5, instr_valid=0, count unchanged; release -> normal advance to 6.
REQ-037 Wrap: branch to 8'hFF with nonzero ROM[FF] and ROM[0] -> next addresses FF, 00; no halt, count +2.
REQ-038 Reset mid-run: reset at PC=7 with count=7 -> next cycle state IDLE, InstAddress=0, count=0, instr_valid=0; start restores run from 0.
REQ-039 Saturation (CNT_W=4): 20 nonzero issues -> issue_count holds at 4'hF; start from HALTED clears to 0.
